rot_xor_alu_seq: RTL and testbench
==================================

Name: rot_xor_alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 4-bit rotate/XOR flag unit.
- Rotates operand b by amount a one bit per clock, with an optional XOR of the rotated value against the original.
- Produces registered NZCV flags.
- Uses valid/ready handshakes on both input and output so it can sit between the operand register stage and the result/flag writeback in the datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), rotate-amount width. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  unit can accept operands
- op  input  2  operation select (see Behaviour)
- a  input  SHW  rotate amount
- b  input  WIDTH  data operand
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- n, z, c, v  output  1 each  negative / zero / carry / overflow flags

Behaviour:
- Ops:
  - 00 ROL: y = rotl(b,a)
  - 01 ROR: y = rotr(b,a)
  - 10 XROL: y = b ^ rotl(b,a)
  - 11 XROR: y = b ^ rotr(b,a)
- Reset (rst_n=0, async):
  - state=IDLE
  - y=0, n=z=c=v=0, out_valid=0
  - internal work/count registers cleared
- in_ready = (state==IDLE), decoded from state. It is 1 during and after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On in_valid && in_ready, latch op, b (original) and b (work copy), and count=a; go to SHIFT.
  - in_valid with in_ready=0 is ignored; the requester must hold it.
- SHIFT:
  - If count!=0: rotate work by 1 in op direction, record the wrapped bit as carry, count--.
  - If count==0: register y, n, z, c, v; set out_valid=1; go to DONE.
- DONE:
  - Hold y, flags and out_valid stable.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - y and flags then retain their values until the next finalize.
- Latency: acceptance cycle = cycle 0; out_valid is high from cycle a+2. So a=0 gives 2 cycles, a=WIDTH-1 gives WIDTH+1.
- No same-cycle result-accept/new-operand-accept overlap. Throughput is one operation per a+3 cycles minimum.
- a >= WIDTH (non-power-of-2 WIDTH): no special case. Rotating a times is inherently modulo WIDTH; latency is still a+2.
- Flags:
  - n = y[WIDTH-1]
  - z = (y==0)
  - c = last bit wrapped during rotation: into LSB for ROL/XROL, into MSB for ROR/XROR. c=0 when a==0.
  - v = n ^ b[WIDTH-1] (sign change relative to the input operand), for all ops.
- Reset mid-operation: immediate abort to IDLE. No out_valid pulse; outputs cleared.

Decomposition:
- Package rot_alu_pkg holds:
  - op_e enum (OP_ROL, OP_ROR, OP_XROL, OP_XROR)
  - state_e enum (IDLE, SHIFT, DONE)
- One combinational sub-module, nzcv_flags, parametrised on WIDTH:
  - inputs: result, original b MSB, carry bit
  - outputs: n, z, c, v
  - reused by later ALU blocks.

Test Plan:
- Reset/idle: assert rst_n=0 mid-sim -> y=0, flags 0, out_valid=0, in_ready=1. Release with in_valid=0 -> no activity.
- WIDTH=4, op=XROL a=1 b=1010 -> y=1111, n=1 z=0 c=1 v=0; out_valid in cycle 3.
- WIDTH=4, op=ROR a=2 b=0101 -> y=0101, n=0 z=0 c=0 v=0. Then op=XROR a=3 b=1111 -> y=0000, z=1 n=0 c=1 v=1, latency 5.
- WIDTH=4, op=ROL a=0 b=0000 -> y=0000, z=1 c=0, latency exactly 2 cycles.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 -> y/flags stable, in_ready=0, second request accepted only the cycle after the out handshake.
- WIDTH=8, op=ROL a=7 b=8'h81 -> y=8'hC0, n=1 z=0 c=0 v=0, latency 9. rst_n pulsed during SHIFT of a repeat -> no out_valid, returns to IDLE.

Source files
------------

// File: rtl/rot_alu_pkg.sv
// Shared types for the sequential rotate/XOR ALU family.
//   op_e    : operation select encoding (matches the 2-bit op port)
//   state_e : control FSM states
package rot_alu_pkg;

   typedef enum logic [1:0] {
      OP_ROL  = 2'b00,
      OP_ROR  = 2'b01,
      OP_XROL = 2'b10,
      OP_XROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/nzcv_flags.sv
// Combinational NZCV flag generator shared by the ALU blocks.
//   result : final datapath result
//   b_msb  : sign bit of the original data operand
//   carry  : carry bit produced by the datapath
//   n/z/c/v: negative, zero, carry, overflow (sign change vs. operand)
module nzcv_flags #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] result,
   input  logic             b_msb,
   input  logic             carry,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v
);

   assign n = result[WIDTH-1];
   assign z = (result == '0);
   assign c = carry;
   assign v = result[WIDTH-1] ^ b_msb;

endmodule

// File: rtl/rot_xor_alu_seq.sv
// Multi-cycle rotate / rotate-XOR unit with registered NZCV flags.
// Rotates b by a positions, one bit per clock, optionally XORing the
// rotated value with the original b.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (op, a, b)
//   op                  : 00 ROL, 01 ROR, 10 XROL, 11 XROR
//   a                   : rotate amount, b : data operand
//   out_valid/out_ready : result handshake (y, n, z, c, v)
module rot_xor_alu_seq
   import rot_alu_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v
);

   state_e           state;
   op_e              op_q;
   logic [WIDTH-1:0] orig_q;
   logic [WIDTH-1:0] work_q;
   logic [SHW-1:0]   count_q;
   logic             carry_q;

   logic             rot_right;
   logic [WIDTH-1:0] rol1;
   logic [WIDTH-1:0] ror1;
   logic [WIDTH-1:0] result;
   logic             f_n, f_z, f_c, f_v;

   assign in_ready  = (state == IDLE);
   assign rot_right = (op_q == OP_ROR) || (op_q == OP_XROR);
   assign rol1      = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
   assign ror1      = {work_q[0], work_q[WIDTH-1:1]};

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      result = work_q;
      if ((op_q == OP_XROL) || (op_q == OP_XROR))
         result = orig_q ^ work_q;
   end

   nzcv_flags #(.WIDTH(WIDTH)) u_flags (
      .result (result),
      .b_msb  (orig_q[WIDTH-1]),
      .carry  (carry_q),
      .n      (f_n),
      .z      (f_z),
      .c      (f_c),
      .v      (f_v)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_ROL;
         orig_q    <= '0;
         work_q    <= '0;
         count_q   <= '0;
         carry_q   <= 1'b0;
         y         <= '0;
         n         <= 1'b0;
         z         <= 1'b0;
         c         <= 1'b0;
         v         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  op_q    <= op_e'(op);
                  orig_q  <= b;
                  work_q  <= b;
                  count_q <= a;
                  // Carry reads 0 when no rotation step happens (a == 0).
                  carry_q <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (count_q != '0) begin
                  // Carry is the bit that wraps around on this step.
                  work_q  <= rot_right ? ror1 : rol1;
                  carry_q <= rot_right ? work_q[0] : work_q[WIDTH-1];
                  count_q <= count_q - SHW'(1);
               end else begin
                  y         <= result;
                  n         <= f_n;
                  z         <= f_z;
                  c         <= f_c;
                  v         <= f_v;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rot_xor_alu_seq.sv
// Directed self-checking bench for rot_xor_alu_seq at WIDTH=4 and WIDTH=8.
module tb_rot_xor_alu_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // WIDTH=4 instance signals
   logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
   logic [1:0] op4 = '0;
   logic [1:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       in_ready4, out_valid4, n4, z4, c4, v4;
   logic [3:0] y4;

   // WIDTH=8 instance signals
   logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic [1:0] op8 = '0;
   logic [2:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       in_ready8, out_valid8, n8, z8, c8, v8;
   logic [7:0] y8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rot_xor_alu_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op4), .a(a4), .b(b4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .y(y4), .n(n4), .z(z4), .c(c4), .v(v4)
   );

   rot_xor_alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op8), .a(a8), .b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .y(y8), .n(n8), .z(z8), .c(c8), .v(v8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one WIDTH=4 operation, then check latency, result and {n,z,c,v}.
   task automatic run4(input string tag, input logic [1:0] o, input logic [1:0] aa,
                       input logic [3:0] bb, input logic [3:0] ey,
                       input logic [3:0] ef, input int elat);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready4), 32'd1);
      op4 = o; a4 = aa; b4 = bb; in_valid4 = 1'b1;
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid4 && lat < 40);
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_y"}, 32'(y4), 32'(ey));
      check({tag, "_nzcv"}, 32'({n4, z4, c4, v4}), 32'(ef));
   endtask

   task automatic pop4(input string tag, input logic [3:0] ey);
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
      @(negedge clk);
      check({tag, "_pop_valid"}, 32'(out_valid4), 32'd0);
      check({tag, "_pop_ready"}, 32'(in_ready4), 32'd1);
      check({tag, "_pop_y_hold"}, 32'(y4), 32'(ey));
   endtask

   initial begin
      int lat;
      int seen;

      // Power-on reset
      #12;
      check("rst_in_ready", 32'(in_ready4), 32'd1);
      check("rst_out_valid", 32'(out_valid4), 32'd0);
      check("rst_y", 32'(y4), 32'd0);
      check("rst_nzcv", 32'({n4, z4, c4, v4}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_activity", 32'({out_valid4, in_ready4}), 32'b01);

      // XROL a=1 b=1010 -> 1111, n=1 z=0 c=1 v=0, latency 3
      run4("xrol", 2'b10, 2'd1, 4'b1010, 4'b1111, 4'b1010, 3);
      pop4("xrol", 4'b1111);

      // ROR a=2 b=0101 -> 0101, flags 0, latency 4
      run4("ror", 2'b01, 2'd2, 4'b0101, 4'b0101, 4'b0000, 4);
      pop4("ror", 4'b0101);

      // XROR a=3 b=1111 -> 0000, n=0 z=1 c=1 v=1, latency 5
      run4("xror", 2'b11, 2'd3, 4'b1111, 4'b0000, 4'b0111, 5);
      pop4("xror", 4'b0000);

      // ROL a=0 b=0000 -> 0000, z=1 c=0, latency 2; left in DONE
      run4("rol0", 2'b00, 2'd0, 4'b0000, 4'b0000, 4'b0100, 2);

      // Backpressure: next request (ROL a=1 b=0001) held while DONE stalls
      op4 = 2'b00; a4 = 2'd1; b4 = 4'b0001; in_valid4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid4), 32'd1);
         check("bp_in_ready", 32'(in_ready4), 32'd0);
         check("bp_y_nzcv", 32'({y4, n4, z4, c4, v4}), 32'b0000_0100);
      end
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
      @(negedge clk);
      check("bp_after_hs_ready", 32'({in_ready4, out_valid4}), 32'b10);
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid4 && lat < 40);
      check("bp2_latency", 32'(lat), 32'd3);
      check("bp2_y", 32'(y4), 32'b0010);
      check("bp2_nzcv", 32'({n4, z4, c4, v4}), 32'b0000);
      pop4("bp2", 4'b0010);

      // WIDTH=8 ROL a=7 b=81 -> C0, n=1 z=0 c=0 v=0, latency 9
      @(negedge clk);
      check("w8_in_ready", 32'(in_ready8), 32'd1);
      op8 = 2'b00; a8 = 3'd7; b8 = 8'h81; in_valid8 = 1'b1;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid8 && lat < 40);
      check("w8_latency", 32'(lat), 32'd9);
      check("w8_y", 32'(y8), 32'hC0);
      check("w8_nzcv", 32'({n8, z8, c8, v8}), 32'b1000);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1 out_ready8 = 1'b0;

      // Repeat, then reset during SHIFT
      @(negedge clk);
      in_valid8 = 1'b1;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      check("w8_abort_busy", 32'(in_ready8), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_w8", 32'({out_valid8, in_ready8, y8, n8, z8, c8, v8}), 32'b01_00000000_0000);
      check("mid_rst_w4", 32'({out_valid4, in_ready4, y4, n4, z4, c4, v4}), 32'b01_0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid8 || !in_ready8 || out_valid4) seen++;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
